// File: rtl/cpu_scoreboard.sv
// cpu_scoreboard: read-after-write hazard unit for the moxie pipeline.
// Tracks in-flight register writes in a PIPE_DEPTH-entry shift register,
// raises the decode stall, bypasses writeback data onto operand reads,
// counts stall cycles and flags writebacks that disagree with the scoreboard.
// Optional feature macro: SCOREBOARD_FWD_EN (final-entry matches forward
// wb_value_i instead of stalling one more cycle).
module cpu_scoreboard #(
  parameter int REG_IDX_W  = 4,
  parameter int DATA_W     = 32,
  parameter int PIPE_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 issue_valid_i,
  input  logic                 issue_wr_en_i,
  input  logic [REG_IDX_W-1:0] issue_wr_idx_i,
  input  logic                 rd_a_en_i,
  input  logic                 rd_b_en_i,
  input  logic [REG_IDX_W-1:0] rd_a_idx_i,
  input  logic [REG_IDX_W-1:0] rd_b_idx_i,
  input  logic [DATA_W-1:0]    rf_a_i,
  input  logic [DATA_W-1:0]    rf_b_i,
  input  logic                 wb_en_i,
  input  logic [REG_IDX_W-1:0] wb_idx_i,
  input  logic [DATA_W-1:0]    wb_value_i,
  input  logic                 flush_i,
  output logic                 stall_o,
  output logic [DATA_W-1:0]    a_value_o,
  output logic [DATA_W-1:0]    b_value_o,
  output logic                 fwd_a_o,
  output logic                 fwd_b_o,
  output logic [CNT_W-1:0]     stall_count_o,
  output logic                 error_o
);

  // Index of the entry that is in writeback this cycle.
  localparam int LAST = PIPE_DEPTH - 1;

  logic [PIPE_DEPTH-1:0] valid_q, valid_d;
  logic [REG_IDX_W-1:0]  idx_q [PIPE_DEPTH];
  logic [REG_IDX_W-1:0]  idx_d [PIPE_DEPTH];
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err_q, err_d;

  logic early_a_s, early_b_s, final_a_s, final_b_s;
  logic haz_a_s, haz_b_s, wb_err_s;

  // Compare both read ports against the early (unproduced) and final entries.
  always_comb begin
    early_a_s = 1'b0;
    early_b_s = 1'b0;
    for (int k = 0; k < LAST; k++) begin
      if (valid_q[k] && (idx_q[k] == rd_a_idx_i)) early_a_s = 1'b1;
      if (valid_q[k] && (idx_q[k] == rd_b_idx_i)) early_b_s = 1'b1;
    end
    early_a_s = early_a_s & rd_a_en_i;
    early_b_s = early_b_s & rd_b_en_i;
    final_a_s = rd_a_en_i & valid_q[LAST] & (idx_q[LAST] == rd_a_idx_i);
    final_b_s = rd_b_en_i & valid_q[LAST] & (idx_q[LAST] == rd_b_idx_i);
  end

`ifdef SCOREBOARD_FWD_EN
  // Final-entry matches are resolved by the bypass, so only early entries stall.
  assign haz_a_s = early_a_s;
  assign haz_b_s = early_b_s;

  // Bypass writeback data onto an operand whenever the read is not stalled.
  always_comb begin
    fwd_a_o = ~rst_i & ~stall_o & rd_a_en_i & wb_en_i & (wb_idx_i == rd_a_idx_i);
    fwd_b_o = ~rst_i & ~stall_o & rd_b_en_i & wb_en_i & (wb_idx_i == rd_b_idx_i);
    if (fwd_a_o) a_value_o = wb_value_i;
    else         a_value_o = rf_a_i;
    if (fwd_b_o) b_value_o = wb_value_i;
    else         b_value_o = rf_b_i;
  end
`else
  // Without the bypass a final-entry match waits for the register file write.
  assign haz_a_s = early_a_s | final_a_s;
  assign haz_b_s = early_b_s | final_b_s;
  assign fwd_a_o   = 1'b0;
  assign fwd_b_o   = 1'b0;
  assign a_value_o = rf_a_i;
  assign b_value_o = rf_b_i;

  logic unused_wb_value_s;
  assign unused_wb_value_s = ^wb_value_i;
`endif

  // A stall only makes sense when decode actually presents an instruction.
  assign stall_o = ~rst_i & issue_valid_i & (haz_a_s | haz_b_s);

  // Writeback must agree with whatever the scoreboard says is retiring now.
  assign wb_err_s = (wb_en_i != valid_q[LAST]) |
                    (wb_en_i & valid_q[LAST] & (wb_idx_i != idx_q[LAST]));

  // Next-state: shift entries, load the accepted issue, apply flush, count, flag.
  always_comb begin
    valid_d[0] = issue_valid_i & issue_wr_en_i & ~stall_o & ~flush_i;
    idx_d[0]   = issue_wr_idx_i;
    for (int k = 1; k < PIPE_DEPTH; k++) begin
      valid_d[k] = valid_q[k-1] & ~flush_i;
      idx_d[k]   = idx_q[k-1];
    end
    if (stall_o && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    else                                    cnt_d = cnt_q;
    err_d = err_q | wb_err_s;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int k = 0; k < PIPE_DEPTH; k++) idx_q[k] <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      for (int k = 0; k < PIPE_DEPTH; k++) idx_q[k] <= idx_d[k];
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign stall_count_o = cnt_q;
  assign error_o       = err_q;

endmodule
